// File: rtl/rgb_pwm_driver.sv
// rtl/rgb_pwm_driver.sv - 15-step RGB LED PWM driver with shared prescaler; RGB_PWM_GAMMA_EN adds a gamma table
module rgb_pwm_driver #(
    parameter int PRESCALE = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] r,
    input  logic [3:0] g,
    input  logic [3:0] b,
    output logic       led_r,
    output logic       led_g,
    output logic       led_b,
    output logic       frame
);

    localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 1);
    localparam logic [3:0]  PHASE_MAX = 4'd14;

    logic [15:0] presc;
    logic [3:0]  phase;
    logic [3:0]  sh_r;
    logic [3:0]  sh_g;
    logic [3:0]  sh_b;
    logic        tick;
    logic        wrap;

    assign tick = (presc == PRESC_MAX);
    assign wrap = tick && (phase == PHASE_MAX);

    function automatic logic [3:0] shape(input logic [3:0] lvl);
`ifdef RGB_PWM_GAMMA_EN
        logic [3:0] res;
        case (lvl)
            4'd0:    res = 4'd0;
            4'd1:    res = 4'd0;
            4'd2:    res = 4'd1;
            4'd3:    res = 4'd1;
            4'd4:    res = 4'd1;
            4'd5:    res = 4'd2;
            4'd6:    res = 4'd2;
            4'd7:    res = 4'd3;
            4'd8:    res = 4'd4;
            4'd9:    res = 4'd5;
            4'd10:   res = 4'd6;
            4'd11:   res = 4'd7;
            4'd12:   res = 4'd9;
            4'd13:   res = 4'd10;
            4'd14:   res = 4'd12;
            default: res = 4'd15;
        endcase
        return res;
`else
        return lvl;
`endif
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
            phase <= '0;
            sh_r  <= '0;
            sh_g  <= '0;
            sh_b  <= '0;
            frame <= 1'b0;
            led_r <= 1'b0;
            led_g <= 1'b0;
            led_b <= 1'b0;
        end else begin
            presc <= tick ? '0 : presc + 16'd1;
            if (tick) begin
                phase <= (phase == PHASE_MAX) ? '0 : phase + 4'd1;
            end
            // Levels only land at the period wrap so mid-period changes never glitch a pulse
            if (wrap) begin
                sh_r <= shape(r);
                sh_g <= shape(g);
                sh_b <= shape(b);
            end
            frame <= wrap;
            led_r <= en && (phase < sh_r);
            led_g <= en && (phase < sh_g);
            led_b <= en && (phase < sh_b);
        end
    end

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// tb/tb_rgb_pwm_driver.sv - self-checking bench for rgb_pwm_driver against a cycle-count reference model
module tb_rgb_pwm_driver;

    localparam int P   = 2;
    localparam int PER = 15 * P;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [3:0] r   = '0;
    logic [3:0] g   = '0;
    logic [3:0] b   = '0;
    logic       led_r, led_g, led_b, frame;

    int checks   = 0;
    int failures = 0;

    // reference model state: edges since reset release and the captured levels
    int n = 0;
    int sh_r = 0, sh_g = 0, sh_b = 0;
    logic exp_r = 0, exp_g = 0, exp_b = 0, exp_f = 0;

    int gtab[16] = '{0, 0, 1, 1, 1, 2, 2, 3, 4, 5, 6, 7, 9, 10, 12, 15};

    rgb_pwm_driver #(.PRESCALE(P)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .r     (r),
        .g     (g),
        .b     (b),
        .led_r (led_r),
        .led_g (led_g),
        .led_b (led_b),
        .frame (frame)
    );

    always #5 clk = ~clk;

    function automatic int lv(input int x);
`ifdef RGB_PWM_GAMMA_EN
        return gtab[x];
`else
        return x;
`endif
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic reset_model();
        n = 0;
        sh_r = 0; sh_g = 0; sh_b = 0;
        exp_r = 0; exp_g = 0; exp_b = 0; exp_f = 0;
    endtask

    // Predict the outputs after the coming edge from the position inside the period
    task automatic model_edge();
        int pos, ph;
        pos   = n % PER;
        ph    = pos / P;
        exp_r = en && (ph < sh_r);
        exp_g = en && (ph < sh_g);
        exp_b = en && (ph < sh_b);
        exp_f = (pos == PER - 1);
        if (pos == PER - 1) begin
            sh_r = lv(int'(r));
            sh_g = lv(int'(g));
            sh_b = lv(int'(b));
        end
        n++;
    endtask

    task automatic tick_cycle();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check("led_r", int'(led_r), int'(exp_r));
        check("led_g", int'(led_g), int'(exp_g));
        check("led_b", int'(led_b), int'(exp_b));
        check("frame", int'(frame), int'(exp_f));
    endtask

    task automatic wait_frame(output int cyc, output int hr);
        cyc = 0;
        hr  = 0;
        for (int i = 0; i < 64; i++) begin
            tick_cycle();
            cyc++;
            hr += int'(led_r);
            if (frame) return;
        end
        check("frame_timeout", 0, 1);
    endtask

    // Count high cycles over the 30 clocks that follow an observed frame
    task automatic measure(input int g_at, input logic [3:0] g_new,
                           input int en_lo, input int en_hi,
                           output int hr, output int hg, output int hb,
                           output int fc, output int fpos);
        hr = 0; hg = 0; hb = 0; fc = 0; fpos = -1;
        for (int i = 0; i < PER; i++) begin
            if (i == g_at)  g  = g_new;
            if (i == en_lo) en = 1'b0;
            if (i == en_hi) en = 1'b1;
            tick_cycle();
            hr += int'(led_r);
            hg += int'(led_g);
            hb += int'(led_b);
            if (frame) begin
                fc++;
                fpos = i;
            end
        end
    endtask

    initial begin
        int cyc, hr, hg, hb, fc, fpos;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_led_r", int'(led_r), 0);
        check("rst_led_g", int'(led_g), 0);
        check("rst_led_b", int'(led_b), 0);
        check("rst_frame", int'(frame), 0);
        rst = 1'b0;
        en  = 1'b1;
        reset_model();

        // all dark for three periods, frame every 30
        wait_frame(cyc, hr);
        check("first_frame_dist", cyc, PER);
        for (int k = 0; k < 3; k++) begin
            measure(-1, 4'd0, -1, -1, hr, hg, hb, fc, fpos);
            check("dark_r", hr, 0);
            check("dark_g", hg, 0);
            check("dark_b", hb, 0);
            check("dark_fcount", fc, 1);
            check("dark_fpos", fpos, PER - 1);
        end

        // mixed levels
        r = 4'd15; g = 4'd5; b = 4'd0;
        wait_frame(cyc, hr);
        measure(-1, 4'd0, -1, -1, hr, hg, hb, fc, fpos);
        check("mix_r", hr, PER);
        check("mix_g", hg, lv(5) * P);
        check("mix_b", hb, 0);

        // mid-period level change applies only from the next period
        measure(14, 4'd10, -1, -1, hr, hg, hb, fc, fpos);
        check("chg_cur_g", hg, lv(5) * P);
        measure(-1, 4'd0, -1, -1, hr, hg, hb, fc, fpos);
        check("chg_next_g", hg, lv(10) * P);

        // 12-clock enable gap
        measure(-1, 4'd0, 8, 20, hr, hg, hb, fc, fpos);
        check("engap_r", hr, PER - 12);
        check("engap_fpos", fpos, PER - 1);

        // gamma-sensitive levels
        r = 4'd8;
        wait_frame(cyc, hr);
        measure(-1, 4'd0, -1, -1, hr, hg, hb, fc, fpos);
        check("lvl8_r", hr, lv(8) * P);
        r = 4'd1;
        wait_frame(cyc, hr);
        measure(-1, 4'd0, -1, -1, hr, hg, hb, fc, fpos);
        check("lvl1_r", hr, lv(1) * P);

        // reset at phase 9 with full red
        r = 4'd15;
        wait_frame(cyc, hr);
        repeat (18) tick_cycle();
        check("pre_rst_led_r", int'(led_r), 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_led_r", int'(led_r), 0);
        check("async_rst_frame", int'(frame), 0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("hold_rst_led_r", int'(led_r), 0);
        rst = 1'b0;
        reset_model();
        wait_frame(cyc, hr);
        check("post_rst_frame_dist", cyc, PER);
        check("post_rst_dark_r", hr, 0);
        measure(-1, 4'd0, -1, -1, hr, hg, hb, fc, fpos);
        check("post_rst_full_r", hr, PER);

        // randomized traffic checked cycle-by-cycle against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) r = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) g = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) b = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) en = ~en;
            tick_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
